pc_redirect_unit: RTL
=====================

Name: pc_redirect_unit

Overview:
- Fetch-side consumer of the 2-bit branch-unit `flag`; owns the architectural program counter.
- Each cycle it selects the next PC: sequential, branch/JAL target, or JALR target.
- On any redirect it holds a multi-cycle flush to the IF/ID, ID/EX and EX/MEM pipeline registers.
- It also tracks halt, misaligned targets and a redirect performance count.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a redirect (legal range 1..7).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- flag  input  2  from branch unit: 00 sequential, 01 branch/JAL taken, 10 JALR, 11 illegal.
- branch_target  input  32  PC+imm, computed in the same stage as `flag`.
- jalr_target  input  32  rs1+imm from the ALU.
- stall  input  1  load-use stall from the hazard unit.
- halt  input  1  ECALL/EBREAK/FENCE-halt from the same stage as `flag`.
- pc  output  32  current fetch PC.
- pc_plus4  output  32  pc + 4, combinational from `pc`.
- flush  output  1  squash enable for IF/ID, ID/EX and EX/MEM.
- halted  output  1  processor stopped.
- misalign_err  output  1  one-cycle pulse on a misaligned redirect target.
- redirect_cnt  output  CNT_W  count of accepted redirects, saturating.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - pc = RESET_PC, state = RUN, flush = 0, halted = 0, misalign_err = 0, redirect_cnt = 0, flush counter = 0.
  - Deassertion is sampled synchronously; the first fetch is from RESET_PC.
- Target selection:
  - flag = 01 selects branch_target.
  - flag = 10 selects {jalr_target[31:1], 1'b0}, i.e. bit 0 is cleared per the ISA.
  - flag = 11 and flag = 00 are treated as sequential.
- States: RUN, FLUSH, HALT.
- RUN:
  - Redirect (flag is 01 or 10) with an aligned target (selected target[1:0] = 00):
    - Next cycle: pc = target, flush = 1, flush counter = FLUSH_CYCLES-1, redirect_cnt += 1 (saturating at all-ones), state → FLUSH.
    - If FLUSH_CYCLES = 1, the state returns to RUN the next cycle.
  - Redirect with a misaligned target (selected target[1] = 1):
    - No PC update and no count.
    - misalign_err pulses high for exactly 1 cycle, flush = 1 for 1 cycle, state → HALT.
  - No redirect and halt = 1: state → HALT, pc frozen, halted = 1 the next cycle.
  - Otherwise: pc += 4 unless stall = 1, in which case pc holds.
- Priority within RUN: redirect > halt > stall.
  - A halt in the same cycle as a redirect is ignored, because the halting instruction lies on the squashed path.
  - A redirect overrides stall, because the stalled instruction is squashed.
- FLUSH:
  - flag and halt are ignored; they belong to squashed instructions.
  - pc advances by 4 per cycle unless stall = 1; flush stays 1.
  - The flush counter decrements each cycle, including stalled cycles. At 0: flush = 0 and state → RUN.
- HALT:
  - pc, redirect_cnt and flush (0 from the second cycle on) are frozen; halted = 1.
  - All inputs are ignored. Only reset exits HALT.
- Reset mid-FLUSH or in HALT: immediate return to reset values; the pending flush count is discarded.
- Wrap-around: pc + 4 wraps modulo 2^32 with no error (0xFFFF_FFFC → 0x0000_0000).
- redirect_cnt saturates at 2^CNT_W-1 and never wraps.
- All outputs except pc_plus4 are registered.
- Latency: flag valid in cycle N → new pc and flush visible in cycle N+1.

Decomposition:
- Add to defines.v:
  - `PCSRC_SEQ 2'b00, `PCSRC_BR 2'b01, `PCSRC_JALR 2'b10, `PCSRC_ILL 2'b11, matching the branch-unit encoding.
  - State encodings `PCR_RUN, `PCR_FLUSH, `PCR_HALT.
- One sub-module is natural: sat_counter (parameter W; ports clk, rst, inc, value). It is used for redirect_cnt and is reusable for other performance counters.
- The flush down-counter stays inline.

Test Plan:
1. Reset with RESET_PC = 0, 5 idle cycles, flag = 00 → pc sequence 0, 4, 8, 12, 16; flush = 0; redirect_cnt = 0.
2. At pc = 0x10, flag = 01, branch_target = 0x40, FLUSH_CYCLES = 2 → next pc = 0x40, flush high for exactly 2 cycles, then pc = 0x44, 0x48; redirect_cnt = 1.
3. flag = 10, jalr_target = 0x0000_0105 → pc = 0x104 (bit 0 cleared), flush asserted. Then flag = 10, jalr_target = 0x0000_0106 → misalign_err pulses for 1 cycle, halted = 1, pc frozen at its prior value.
4. stall = 1 together with flag = 01, target 0x80 → pc = 0x80 (redirect wins). Then stall = 1 alone in FLUSH → pc holds while flush still counts down.
5. halt = 1 and flag = 01 in the same cycle → redirect taken, no halt. Later halt = 1 alone → halted = 1, pc frozen; flag = 01 thereafter is ignored.
6. Assert rst low mid-FLUSH with pc = 0x200 → pc = RESET_PC and flush = 0 immediately, asynchronously. With CNT_W = 2, 5 redirects → redirect_cnt saturates at 3.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared encodings and helpers for the fetch-side PC redirect unit.
// Branch-unit flag encoding and the redirect FSM state type live here.
package pc_redirect_unit_pkg;

   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JALR = 2'b10;
   localparam logic [1:0] PCSRC_ILL  = 2'b11;

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StFlush = 2'b01,
      StHalt  = 2'b10
   } pcr_state_e;

   function automatic logic is_redirect(input logic [1:0] flag);
      logic r;
      r = 1'b0;
      case (flag)
         PCSRC_BR, PCSRC_JALR: r = 1'b1;
         PCSRC_SEQ, PCSRC_ILL: r = 1'b0;
         default:              r = 1'b0;
      endcase
      return r;
   endfunction

   // JALR clears bit 0 of the computed address, as the ISA requires.
   function automatic logic [31:0] select_target(input logic [1:0]  flag,
                                                 input logic [31:0] branch_target,
                                                 input logic [31:0] jalr_target);
      logic [31:0] t;
      t = branch_target;
      if (flag == PCSRC_JALR) begin
         t = {jalr_target[31:1], 1'b0};
      end
      return t;
   endfunction

endpackage

// File: rtl/pc_redirect_unit_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Used for the redirect performance count.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign value = cnt_q;

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the fetch PC: selects sequential/branch/JALR next PC, holds a multi-cycle
// pipeline flush after each redirect, and tracks halt and misaligned targets.
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       flag,
   input  logic [31:0]      branch_target,
   input  logic [31:0]      jalr_target,
   input  logic             stall,
   input  logic             halt,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             flush,
   output logic             halted,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt
);

   // The first flush cycle is the redirect cycle itself, so the counter starts one short.
   localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

   pcr_state_e  state_q;
   logic [31:0] pc_q;
   logic [2:0]  fcnt_q;
   logic        flush_q;
   logic        halted_q;
   logic        misalign_q;

   logic [31:0] target;
   logic        redirect_req;
   logic        target_misaligned;
   logic        accept_redirect;

   always_comb begin
      target            = select_target(flag, branch_target, jalr_target);
      redirect_req      = is_redirect(flag);
      target_misaligned = |target[1:0];
      accept_redirect   = (state_q == StRun) && redirect_req && !target_misaligned;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StRun;
         pc_q       <= RESET_PC;
         fcnt_q     <= '0;
         flush_q    <= 1'b0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         unique case (state_q)
            StRun: begin
               if (redirect_req) begin
                  if (target_misaligned) begin
                     misalign_q <= 1'b1;
                     flush_q    <= 1'b1;
                     halted_q   <= 1'b1;
                     state_q    <= StHalt;
                  end else begin
                     pc_q    <= target;
                     flush_q <= 1'b1;
                     fcnt_q  <= FlushInit;
                     state_q <= StFlush;
                  end
               end else if (halt) begin
                  halted_q <= 1'b1;
                  state_q  <= StHalt;
               end else if (!stall) begin
                  pc_q <= pc_q + 32'd4;
               end
            end
            StFlush: begin
               if (!stall) begin
                  pc_q <= pc_q + 32'd4;
               end
               if (fcnt_q == 3'd0) begin
                  flush_q <= 1'b0;
                  state_q <= StRun;
               end else begin
                  fcnt_q <= fcnt_q - 3'd1;
               end
            end
            StHalt: begin
               flush_q <= 1'b0;
            end
            default: begin
               flush_q  <= 1'b0;
               halted_q <= 1'b1;
               state_q  <= StHalt;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_redirect_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept_redirect),
      .value (redirect_cnt)
   );

   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign flush        = flush_q;
   assign halted       = halted_q;
   assign misalign_err = misalign_q;

endmodule
